mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares one single-port data memory (comb read, write on posedge clk) between two requesters.
// - Port 0 is instruction fetch; port 1 is load/store from the MEM stage.
// - Round-robin arbitration with a burst limit, registered read data, one access per cycle.
// - Sits between the pipeline stages and the memory instance in the processor top level.
// PARAMETERS
// - ADDR_WIDTH  8   memory word-address width
// - DATA_WIDTH  32  memory word width
// - MAX_BURST   4   max consecutive grants to one port while the other port is requesting (>=1)
// PORTS
// - clk          in   1           clock; all state updates on posedge
// - reset        in   1           synchronous, active-high reset
// - req_0/req_1  in   1           port n request; held until gnt_n is seen high
// - we_0/we_1    in   1           port n write enable (1 = store, 0 = load)
// - addr_0/1     in   ADDR_WIDTH  port n word address
// - wdata_0/1    in   DATA_WIDTH  port n write data
// - gnt_0/gnt_1  out  1           port n access accepted this cycle (comb)
// - rdata_0/1    out  DATA_WIDTH  port n read data (registered)
// - rvalid_0/1   out  1           rdata_n valid; one-cycle pulse
// - mem_addr     out  ADDR_WIDTH  to memory addr
// - mem_wdata    out  DATA_WIDTH  to memory data_in
// - mem_write    out  1           to memory write
// - mem_rdata    in   DATA_WIDTH  from memory data_out
// BEHAVIOUR
// - State: owner {NONE, P0, P1}; last_served {P0, P1}; burst_cnt (clog2(MAX_BURST)+1 bits, saturating).
// - Reset values: owner=NONE, last_served=P1 (port 0 wins the first tie), burst_cnt=0.
//   Also gnt_n=0, rvalid_n=0, rdata_n=0.
// - gnt_n = (owner==Pn) & req_n & ~reset.
// - Memory mux:
//   - On gnt_n: mem_addr=addr_n, mem_wdata=wdata_n, mem_write=we_n.
//   - With no grant: all memory outputs are 0.
//   - mem_write is forced to 0 whenever reset is high, so no write commits in the reset cycle.
// - At posedge with gnt_n:
//   - rvalid_n <= ~we_n; rdata_n <= mem_rdata when ~we_n, else rdata_n is held.
//   - The write commits in memory at that same edge.
// - rvalid_n is cleared on any edge without gnt_n. Read latency: data 1 cycle after gnt.
// - Next owner, evaluated at each posedge:
//   - gnt_n & req_other & burst_cnt==MAX_BURST-1: owner <= other, burst_cnt <= 0, last_served <= Pn.
//   - gnt_n otherwise: owner stays, burst_cnt <= burst_cnt+1 (saturating), last_served <= Pn.
//   - No grant this cycle (owner NONE or owner dropped req):
//     - Only one port requesting: owner <= that port.
//     - Both requesting: owner <= the port != last_served.
//     - Neither requesting: owner <= NONE.
//     - In all three cases: burst_cnt <= 0.
// - Timing:
//   - Idle-to-grant latency: 1 cycle (req seen at edge t, gnt high in cycle t+1).
//   - Ownership hand-off costs no dead cycle.
//   - Streaming: one access per cycle.
// - Boundary cases:
//   - Requester drops req while it is owner: no access that cycle; re-arbitrate at the next edge.
//   - MAX_BURST=1: strict alternation while both ports request.
//   - burst_cnt saturates; it never wraps.
//   - Reset mid-burst: owner returns to NONE and pending rvalid is cleared.
// - req_n must not depend combinationally on gnt_n.
// CONFIGURATION
// - MEM_ARB_FIXED_PRIO_EN defined:
//   - Port 1 has absolute priority: if req_1 is high at any edge, owner <= P1.
//   - This preempts P0 after its current grant.
//   - Burst limit does not apply to P1; last_served and round-robin are unused.
// - MEM_ARB_FIXED_PRIO_EN undefined: round-robin plus MAX_BURST as above.
// TESTING
// - Reset: hold reset 2 cycles with req_0=req_1=1 -> gnt_*=0, mem_write=0, rvalid_*=0 throughout.
// - Single read:
//   - Stimulus: mem[0x10]=0xDEADBEEF; req_0=1, we_0=0, addr_0=0x10 at cycle 0.
//   - Response: gnt_0=1 in cycle 1; rvalid_0=1, rdata_0=0xDEADBEEF in cycle 2.
// - Write then read: port 1 writes 0x12345678 to 0x20, then reads 0x20 -> rdata_1=0x12345678.
// - Contention:
//   - Stimulus: both ports stream from idle, MAX_BURST=4.
//   - Response: gnt_0 x4, gnt_1 x4, gnt_0 x4, ...; never both gnt high; no idle cycles.
// - Drop: owner P0 drops req mid-burst with req_1 high -> one cycle no grant, then gnt_1.
// - With MEM_ARB_FIXED_PRIO_EN:
//   - Stimulus: port 0 streaming; req_1 raised at cycle 5.
//   - Response: gnt_1 in cycle 6 and held while req_1 stays high.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: both ports' request/write channels and
// their grant/read-return signals. The arbiter takes the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_0;
  logic                  req_1;
  logic                  we_0;
  logic                  we_1;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic [DATA_WIDTH-1:0] wdata_1;
  logic                  gnt_0;
  logic                  gnt_1;
  logic [DATA_WIDTH-1:0] rdata_0;
  logic [DATA_WIDTH-1:0] rdata_1;
  logic                  rvalid_0;
  logic                  rvalid_1;

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    input  gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    output gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin with a burst
// limit, or port-1 fixed priority when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
`ifndef MEM_ARB_FIXED_PRIO_EN
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
`endif

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;
  typedef enum logic {LAST_P0, LAST_P1} port_e;

  owner_e                owner_q, owner_d;
  port_e                 last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  rvalid_0_q, rvalid_1_q;
  logic [DATA_WIDTH-1:0] rdata_0_q, rdata_1_q;
  logic                  gnt_0, gnt_1;

  assign gnt_0 = (owner_q == OWN_P0) && bus.req_0 && !reset;
  assign gnt_1 = (owner_q == OWN_P1) && bus.req_1 && !reset;

  assign bus.gnt_0    = gnt_0;
  assign bus.gnt_1    = gnt_1;
  assign bus.rvalid_0 = rvalid_0_q;
  assign bus.rvalid_1 = rvalid_1_q;
  assign bus.rdata_0  = rdata_0_q;
  assign bus.rdata_1  = rdata_1_q;

  // Grants already include ~reset, so no write can commit during reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    if (gnt_0) begin
      mem_addr  = bus.addr_0;
      mem_wdata = bus.wdata_0;
      mem_write = bus.we_0;
    end else if (gnt_1) begin
      mem_addr  = bus.addr_1;
      mem_wdata = bus.wdata_1;
      mem_write = bus.we_1;
    end
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    if (gnt_0) begin
      last_d = LAST_P0;
    end else if (gnt_1) begin
      last_d = LAST_P1;
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (gnt_0 || gnt_1) begin
      cnt_d = cnt_inc;
    end
    if (bus.req_1) begin
      owner_d = OWN_P1;
    end else if (bus.req_0) begin
      owner_d = OWN_P0;
    end else begin
      owner_d = OWN_NONE;
    end
`else
    // >= rather than == so a count that ran past the limit while the other port
    // was idle still hands off once that port starts requesting.
    if (gnt_0) begin
      if (bus.req_1 && cnt_q >= BURST_LAST) begin
        owner_d = OWN_P1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (gnt_1) begin
      if (bus.req_0 && cnt_q >= BURST_LAST) begin
        owner_d = OWN_P0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (bus.req_0 && bus.req_1) begin
      owner_d = (last_q == LAST_P0) ? OWN_P1 : OWN_P0;
    end else if (bus.req_0) begin
      owner_d = OWN_P0;
    end else if (bus.req_1) begin
      owner_d = OWN_P1;
    end else begin
      owner_d = OWN_NONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_q     <= LAST_P1;
      cnt_q      <= '0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rvalid_0_q <= gnt_0 && !bus.we_0;
      rvalid_1_q <= gnt_1 && !bus.we_1;
      if (gnt_0 && !bus.we_0) begin
        rdata_0_q <= mem_rdata;
      end
      if (gnt_1 && !bus.we_1) begin
        rdata_1_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, write-then-read, contention
// (MAX_BURST=4 and MAX_BURST=1), owner drop, and fixed priority under its macro.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  logic [AW-1:0] mem_addr, m1_addr;
  logic [DW-1:0] mem_wdata, m1_wdata, mem_rdata, m1_rdata;
  logic          mem_write, m1_write;
  logic [DW-1:0] mem [256];

  assign mem_rdata = mem[mem_addr];
  assign m1_rdata  = '0;
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_write(m1_write), .mem_rdata(m1_rdata)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic e0, e1, p0, p1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h01] = 32'hA1A1A1A1;
    mem[8'h02] = 32'hB2B2B2B2;
    reset = 1'b1;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1; bus.we_0 = 1'b0; bus.we_1 = 1'b0;
    bus.addr_0 = '0; bus.addr_1 = '0; bus.wdata_0 = '0; bus.wdata_1 = '0;
    bus1.req_0 = 1'b0; bus1.req_1 = 1'b0; bus1.we_0 = 1'b0; bus1.we_1 = 1'b0;
    bus1.addr_0 = '0; bus1.addr_1 = '0; bus1.wdata_0 = '0; bus1.wdata_1 = '0;

    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_gnt0", bus.gnt_0, 0);
      check("rst_gnt1", bus.gnt_1, 0);
      check("rst_mwr", mem_write, 0);
      check("rst_rv0", bus.rvalid_0, 0);
      check("rst_rv1", bus.rvalid_1, 0);
      check("rst_rd0", bus.rdata_0, 0);
    end
    reset = 1'b0; bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    step();

    // single read from port 0
    bus.req_0 = 1'b1; bus.addr_0 = 8'h10; #1;
    check("rd_c0_gnt0", bus.gnt_0, 0);
    step();
    check("rd_c1_gnt0", bus.gnt_0, 1);
    check("rd_c1_maddr", mem_addr, 32'h10);
    check("rd_c1_mwr", mem_write, 0);
    step();
    bus.req_0 = 1'b0; #1;
    check("rd_c2_rv0", bus.rvalid_0, 1);
    check("rd_c2_rd0", bus.rdata_0, 32'hDEADBEEF);
    check("rd_c2_gnt0", bus.gnt_0, 0);
    step();
    check("rd_c3_rv0", bus.rvalid_0, 0);
    check("rd_c3_hold", bus.rdata_0, 32'hDEADBEEF);

    // port 1 write then read back
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 8'h20; bus.wdata_1 = 32'h12345678; #1;
    check("wr_idle_gnt1", bus.gnt_1, 0);
    step();
    check("wr_gnt1", bus.gnt_1, 1);
    check("wr_mwr", mem_write, 1);
    check("wr_maddr", mem_addr, 32'h20);
    check("wr_mwdata", mem_wdata, 32'h12345678);
    step();
    bus.we_1 = 1'b0; #1;
    check("rb_gnt1", bus.gnt_1, 1);
    check("rb_mwr", mem_write, 0);
    check("rb_rv1_after_wr", bus.rvalid_1, 0);
    step();
    bus.req_1 = 1'b0; #1;
    check("rb_rv1", bus.rvalid_1, 1);
    check("rb_rd1", bus.rdata_1, 32'h12345678);
    step();
    check("rb_rv1_clr", bus.rvalid_1, 0);

`ifndef MEM_ARB_FIXED_PRIO_EN
    // both ports stream from idle
    bus.req_0 = 1'b1; bus.req_1 = 1'b1; bus.addr_0 = 8'h01; bus.addr_1 = 8'h02;
    bus1.req_0 = 1'b1; bus1.req_1 = 1'b1; #1;
    check("ct_idle_gnt0", bus.gnt_0, 0);
    check("ct_idle_gnt1", bus.gnt_1, 0);
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      e0 = ((k / 4) % 2) == 0;
      e1 = !e0;
      check($sformatf("ct_gnt0_k%0d", k), bus.gnt_0, e0);
      check($sformatf("ct_gnt1_k%0d", k), bus.gnt_1, e1);
      check($sformatf("ct_rv0_k%0d", k), bus.rvalid_0, p0);
      check($sformatf("ct_rv1_k%0d", k), bus.rvalid_1, p1);
      check($sformatf("ct_rd0_k%0d", k), bus.rdata_0, (k >= 1) ? 32'hA1A1A1A1 : 32'hDEADBEEF);
      check($sformatf("ct_rd1_k%0d", k), bus.rdata_1, (k >= 5) ? 32'hB2B2B2B2 : 32'h12345678);
      check($sformatf("b1_gnt0_k%0d", k), bus1.gnt_0, (k % 2) == 0);
      check($sformatf("b1_gnt1_k%0d", k), bus1.gnt_1, (k % 2) == 1);
      p0 = e0; p1 = e1;
    end

    // owner drops its request mid-burst while the other port waits
    step();
    bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus1.req_0 = 1'b0; bus1.req_1 = 1'b0; #1;
    check("dr_idle_gnt1", bus.gnt_1, 0);
    step();
    bus.req_0 = 1'b1; #1;
    check("dr_arb_gnt0", bus.gnt_0, 0);
    step();
    bus.req_1 = 1'b1; #1;
    check("dr_b0_gnt0", bus.gnt_0, 1);
    check("dr_b0_gnt1", bus.gnt_1, 0);
    step();
    check("dr_b1_gnt0", bus.gnt_0, 1);
    step();
    bus.req_0 = 1'b0; #1;
    check("dr_gap_gnt0", bus.gnt_0, 0);
    check("dr_gap_gnt1", bus.gnt_1, 0);
    check("dr_gap_maddr", mem_addr, 0);
    step();
    check("dr_hand_gnt1", bus.gnt_1, 1);
    check("dr_hand_maddr", mem_addr, 32'h02);
    bus.req_1 = 1'b0;
`else
    // port 0 streams; port 1 preempts from cycle 5 to cycle 10
    bus.req_0 = 1'b1; bus.addr_0 = 8'h01; bus.addr_1 = 8'h02; #1;
    check("fp_c0_gnt0", bus.gnt_0, 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 5) bus.req_1 = 1'b1;
      if (c == 11) bus.req_1 = 1'b0;
      #1;
      e1 = (c >= 6) && (c <= 10);
      e0 = (c <= 5) || (c >= 12);
      check($sformatf("fp_gnt0_c%0d", c), bus.gnt_0, e0);
      check($sformatf("fp_gnt1_c%0d", c), bus.gnt_1, e1);
    end
    bus.req_0 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
